// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module     : button_event
// Description: Turns a debounced button level into single-cycle event strobes
//              (press, release, click, long-press, auto-repeat), a HELD level
//              and a wrapping 8-bit press counter. All outputs are registered.
// Revision   : 1.0 - initial release
// ============================================================================
module button_event #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int REPEAT_EN     = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       btn,
  output logic       press_o,
  output logic       release_o,
  output logic       click_o,
  output logic       long_o,
  output logic       repeat_o,
  output logic       held_o,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  // Terminal counts: the counter restarts at 0 on every state entry, so the
  // threshold edge is the one where it already holds N-1.
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic                 REPEAT_ON   = (REPEAT_EN != 0);

  state_t               state;
  logic                 btn_q;
  logic [CNT_WIDTH-1:0] count;
  logic                 rise;
  logic                 fall;

  // btn_q resets to 0 so a button already down at reset release reads as a press
  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  // One-cycle delayed copy of the button level for edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  // Event FSM; strobes default low each cycle, release always wins over a
  // threshold reached on the same edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      count     <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      click_o   <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
      held_o    <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      click_o   <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            state     <= PRESSED;
            press_o   <= 1'b1;
            count     <= '0;
            press_cnt <= press_cnt + 8'd1;
          end
        end

        PRESSED: begin
          if (fall) begin
            state     <= IDLE;
            release_o <= 1'b1;
            click_o   <= 1'b1;
            count     <= '0;
          end else if (count == HOLD_LAST) begin
            state  <= HELD;
            long_o <= 1'b1;
            held_o <= 1'b1;
            count  <= '0;
          end else begin
            count <= count + CNT_WIDTH'(1);
          end
        end

        HELD: begin
          if (fall) begin
            state     <= IDLE;
            release_o <= 1'b1;
            held_o    <= 1'b0;
            count     <= '0;
          end else begin
            held_o <= 1'b1;
            if (count == REPEAT_LAST) begin
              count    <= '0;
              repeat_o <= REPEAT_ON;
            end else begin
              count <= count + CNT_WIDTH'(1);
            end
          end
        end

        default: begin
          state  <= IDLE;
          held_o <= 1'b0;
          count  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// Module     : tb_button_event
// Description: Directed self-checking bench for button_event (HOLD=10,
//              REPEAT=4), with a second instance built with REPEAT_EN=0.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_button_event;

  logic       clk;
  logic       nrst;
  logic       btn;

  logic       press_o, release_o, click_o, long_o, repeat_o, held_o;
  logic [7:0] press_cnt;
  logic       press2, release2, click2, long2, repeat2, held2;
  logic [7:0] press_cnt2;

  logic [5:0] outs;
  logic [5:0] outs2;

  int         tests;
  int         fails;
  logic [7:0] exp_cnt;

  // Bit order: press, release, click, long, repeat, held
  assign outs  = {press_o, release_o, click_o, long_o, repeat_o, held_o};
  assign outs2 = {press2, release2, click2, long2, repeat2, held2};

  button_event #(
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .REPEAT_EN    (1),
    .CNT_WIDTH    (16)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .btn      (btn),
    .press_o  (press_o),
    .release_o(release_o),
    .click_o  (click_o),
    .long_o   (long_o),
    .repeat_o (repeat_o),
    .held_o   (held_o),
    .press_cnt(press_cnt)
  );

  button_event #(
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .REPEAT_EN    (0),
    .CNT_WIDTH    (16)
  ) dut_norep (
    .clk      (clk),
    .nrst     (nrst),
    .btn      (btn),
    .press_o  (press2),
    .release_o(release2),
    .click_o  (click2),
    .long_o   (long2),
    .repeat_o (repeat2),
    .held_o   (held2),
    .press_cnt(press_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    btn  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn = ~btn;
      tick();
      tests++;
      if (outs !== 6'b000000 || press_cnt !== 8'd0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: outs=%b cnt=%0d, required outs=000000 cnt=0", i, outs, press_cnt);
      end
    end
    btn  = 1'b0;
    nrst = 1'b1;
    tick();
    tests++;
    if (outs !== 6'b000000 || press_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_release: outs=%b cnt=%0d, required outs=000000 cnt=0", outs, press_cnt);
    end
    exp_cnt = 8'd0;
  endtask

  task automatic test_short_press();
    btn = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    tick();
    tests++;
    if (outs !== 6'b100000 || press_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL short_press: outs=%b cnt=%0d, required outs=100000 cnt=%0d", outs, press_cnt, exp_cnt);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      tests++;
      if (outs !== 6'b000000) begin
        fails++;
        $display("FAIL short_hold[%0d]: outs=%b, required 000000", i, outs);
      end
    end
    btn = 1'b0;
    tick();
    tests++;
    if (outs !== 6'b011000) begin
      fails++;
      $display("FAIL short_release: outs=%b, required 011000", outs);
    end
    tick();
    tests++;
    if (outs !== 6'b000000 || press_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL short_after: outs=%b cnt=%0d, required outs=000000 cnt=%0d", outs, press_cnt, exp_cnt);
    end
  endtask

  // 30 cycles high: long at +10, repeats at +14,+18,+22,+26; REPEAT_EN=0 copy never repeats
  task automatic test_long_repeat();
    logic [5:0] exp;
    logic [5:0] exp2;
    btn = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    for (int j = 0; j < 30; j++) begin
      tick();
      exp = 6'b000000;
      if (j == 0) begin
        exp = 6'b100000;
      end else if (j >= 10) begin
        exp[0] = 1'b1;
        if (j == 10) exp[2] = 1'b1;
        else if (((j - 10) % 4) == 0) exp[1] = 1'b1;
      end
      exp2 = exp & 6'b111101;
      tests++;
      if (outs !== exp || outs2 !== exp2) begin
        fails++;
        $display("FAIL long_repeat[%0d]: outs=%b outs_norep=%b, required %b / %b", j, outs, outs2, exp, exp2);
      end
    end
    btn = 1'b0;
    tick();
    tests++;
    if (outs !== 6'b010000 || outs2 !== 6'b010000 || press_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL long_release: outs=%b outs_norep=%b cnt=%0d, required 010000 cnt=%0d", outs, outs2, press_cnt, exp_cnt);
    end
    tick();
    tests++;
    if (outs !== 6'b000000) begin
      fails++;
      $display("FAIL long_after: outs=%b, required 000000", outs);
    end
  endtask

  // Release sampled on the terminal count in PRESSED and in HELD
  task automatic test_boundary();
    btn = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    tick();
    tests++;
    if (outs !== 6'b100000) begin
      fails++;
      $display("FAIL bound_press: outs=%b, required 100000", outs);
    end
    for (int j = 1; j < 10; j++) tick();
    btn = 1'b0;
    tick();
    tests++;
    if (outs !== 6'b011000) begin
      fails++;
      $display("FAIL bound_hold_release: outs=%b, required 011000", outs);
    end
    tick();
    tests++;
    if (outs !== 6'b000000) begin
      fails++;
      $display("FAIL bound_no_long: outs=%b, required 000000", outs);
    end

    btn = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    for (int j = 0; j < 14; j++) tick();
    tests++;
    if (outs !== 6'b000001) begin
      fails++;
      $display("FAIL bound_held_pre: outs=%b, required 000001", outs);
    end
    btn = 1'b0;
    tick();
    tests++;
    if (outs !== 6'b010000 || outs2 !== 6'b010000 || press_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL bound_repeat_release: outs=%b outs_norep=%b cnt=%0d, required 010000 cnt=%0d", outs, outs2, press_cnt, exp_cnt);
    end
  endtask

  // Async reset mid-HELD, then a button held through reset release
  task automatic test_async_reset();
    btn = 1'b1;
    for (int j = 0; j < 13; j++) tick();
    tests++;
    if (held_o !== 1'b1) begin
      fails++;
      $display("FAIL async_pre_held: held_o=%b, required 1", held_o);
    end
    #1;
    nrst = 1'b0;
    #1;
    tests++;
    if (outs !== 6'b000000 || press_cnt !== 8'd0 || outs2 !== 6'b000000) begin
      fails++;
      $display("FAIL async_clear: outs=%b outs_norep=%b cnt=%0d, required 000000 cnt=0", outs, outs2, press_cnt);
    end
    #1;
    nrst = 1'b1;
    tick();
    tests++;
    if (outs !== 6'b100000 || press_cnt !== 8'd1) begin
      fails++;
      $display("FAIL async_press_after: outs=%b cnt=%0d, required outs=100000 cnt=1", outs, press_cnt);
    end
    btn = 1'b0;
    tick();
    tests++;
    if (outs !== 6'b011000) begin
      fails++;
      $display("FAIL async_click: outs=%b, required 011000", outs);
    end
  endtask

  // 256 single-cycle pulses from a fresh reset: counter wraps back to 0
  task automatic test_back_to_back();
    btn  = 1'b0;
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      btn = 1'b1;
      exp_cnt = exp_cnt + 8'd1;
      tick();
      tests++;
      if (outs !== 6'b100000 || press_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL pulse_press[%0d]: outs=%b cnt=%0d, required outs=100000 cnt=%0d", i, outs, press_cnt, exp_cnt);
      end
      btn = 1'b0;
      tick();
      tests++;
      if (outs !== 6'b011000) begin
        fails++;
        $display("FAIL pulse_release[%0d]: outs=%b, required 011000", i, outs);
      end
    end
    tests++;
    if (press_cnt !== 8'd0) begin
      fails++;
      $display("FAIL cnt_wrap: press_cnt=%0d, required 0", press_cnt);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cnt = 8'd0;
    nrst    = 1'b0;
    btn     = 1'b0;
    test_reset();
    test_short_press();
    test_long_repeat();
    test_boundary();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
